display_num_7seg: RTL and testbench

Downstream consumer of the 0–99 seconds counter. It takes the counter's binary `number` and converts it to two BCD digits with an iterative shift-add-3 (double-dabble) engine. It then drives two active-low 7-segment displays (units on `hex0`, tens on `hex1`). A conversion starts whenever the input differs from the last converted value, so the display tracks every increment, wrap and counter reset without needing the tick.

---
 rtl/display_pkg.sv | 35 +++
 rtl/seg7_decoder.sv | 28 ++
 rtl/display_num_7seg.sv | 123 ++++++++++++
 tb/tb_display_num_7seg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the binary-to-7-segment display path.
package display_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned NUM_W   = 8;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned SREG_W  = 3 * BCD_W + NUM_W;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // Active-low segment codes, bit order gfedcba
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  // Double-dabble correction: nibbles of 5 or more get 3 added, no carry out
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] nib);
    add3 = (nib >= BCD_W'(5)) ? BCD_W'(nib + BCD_W'(3)) : nib;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [SEG_W-1:0] seg
);

  // Digits 0-9 map to glyphs; 10-14 blank; 15 shows a dash
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd15: seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_num_7seg.sv
// Converts the 0-99 counter value to BCD (iterative double-dabble) and
// drives two active-low 7-segment displays; reconverts on any input change.
module display_num_7seg
  import display_pkg::*;
#(
  parameter bit BLANK_LEAD_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_W-1:0] number,
  output logic [SEG_W-1:0] hex0,
  output logic [SEG_W-1:0] hex1,
  output logic [BCD_W-1:0] bcd_units,
  output logic [BCD_W-1:0] bcd_tens,
  output logic             busy,
  output logic             range_err
);

  localparam logic [SEG_W-1:0] HEX1_RST = BLANK_LEAD_ZERO ? SEG_BLANK : SEG_0;

  state_t              state_q;
  logic [NUM_W-1:0]    last_num_q;
  logic [SREG_W-1:0]   sreg_q;
  logic [SREG_W-1:0]   sreg_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [SEG_W-1:0]    hex0_q;
  logic [SEG_W-1:0]    hex1_q;
  logic [BCD_W-1:0]    bcd_units_q;
  logic [BCD_W-1:0]    bcd_tens_q;
  logic                busy_q;
  logic                range_err_q;

  logic [BCD_W-1:0]    hund_w;
  logic [BCD_W-1:0]    tens_w;
  logic [BCD_W-1:0]    units_w;
  logic [SEG_W-1:0]    seg_tens_w;
  logic [SEG_W-1:0]    seg_units_w;

  assign hund_w  = sreg_q[19:16];
  assign tens_w  = sreg_q[15:12];
  assign units_w = sreg_q[11:8];

  // One double-dabble step: correct each BCD nibble, then shift left by one
  always_comb begin
    sreg_d = sreg_q;
    sreg_d = {add3(hund_w), add3(tens_w), add3(units_w), sreg_q[7:0]};
    sreg_d = {sreg_d[SREG_W-2:0], 1'b0};
  end

  seg7_decoder u_dec_tens (
    .digit (tens_w),
    .seg   (seg_tens_w)
  );

  seg7_decoder u_dec_units (
    .digit (units_w),
    .seg   (seg_units_w)
  );

  // Conversion FSM with registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_num_q  <= '0;
      sreg_q      <= '0;
      cnt_q       <= '0;
      hex0_q      <= SEG_0;
      hex1_q      <= HEX1_RST;
      bcd_units_q <= '0;
      bcd_tens_q  <= '0;
      busy_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (number != last_num_q) begin
            sreg_q     <= {12'b0, number};
            last_num_q <= number;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sreg_q <= sreg_d;
          cnt_q  <= CNT_W'(cnt_q + CNT_W'(1));
          if (cnt_q == CNT_W'(7)) begin
            state_q <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (hund_w == '0) begin
            bcd_tens_q  <= tens_w;
            bcd_units_q <= units_w;
            range_err_q <= 1'b0;
            hex0_q      <= seg_units_w;
            hex1_q      <= (BLANK_LEAD_ZERO && (tens_w == '0)) ? SEG_BLANK : seg_tens_w;
          end else begin
            bcd_tens_q  <= 4'hF;
            bcd_units_q <= 4'hF;
            range_err_q <= 1'b1;
            hex0_q      <= SEG_DASH;
            hex1_q      <= SEG_DASH;
          end
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hex0      = hex0_q;
  assign hex1      = hex1_q;
  assign bcd_units = bcd_units_q;
  assign bcd_tens  = bcd_tens_q;
  assign busy      = busy_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_display_num_7seg.sv
// Directed bench for display_num_7seg (default and leading-zero-blank builds).
module tb_display_num_7seg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] number;

  logic [6:0] hex0_a, hex1_a, hex0_b, hex1_b;
  logic [3:0] units_a, tens_a, units_b, tens_b;
  logic       busy_a, rerr_a, busy_b, rerr_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  display_num_7seg #(.BLANK_LEAD_ZERO(1'b0)) dut_a (
    .clk(clk), .reset(reset), .number(number),
    .hex0(hex0_a), .hex1(hex1_a), .bcd_units(units_a), .bcd_tens(tens_a),
    .busy(busy_a), .range_err(rerr_a)
  );

  display_num_7seg #(.BLANK_LEAD_ZERO(1'b1)) dut_b (
    .clk(clk), .reset(reset), .number(number),
    .hex0(hex0_b), .hex1(hex1_b), .bcd_units(units_b), .bcd_tens(tens_b),
    .busy(busy_b), .range_err(rerr_b)
  );

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Drive a new value and let the full conversion complete (E0..E0+9)
  task automatic apply(input logic [7:0] v);
    number = v;
    step(10);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    number = 8'd0;
    step(3);
    reset = 1'b0;
    n_checks++;
    if (hex0_a !== 7'b1000000 || hex1_a !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_hex: got %b %b want 1000000 1000000", hex1_a, hex0_a);
    end
    n_checks++;
    if (hex1_b !== 7'b1111111 || hex0_b !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_hex_blank: got %b %b want 1111111 1000000", hex1_b, hex0_b);
    end
    n_checks++;
    if (tens_a !== 4'd0 || units_a !== 4'd0 || rerr_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_bcd: got %h%h err %b want 00 err 0", tens_a, units_a, rerr_a);
    end
    for (int i = 0; i < 12; i++) begin
      step(1);
      n_checks++;
      if (busy_a !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle_busy: cycle %0d got %b want 0", i, busy_a);
      end
    end
  endtask

  task automatic test_convert_47();
    int busy_cycles;
    busy_cycles = 0;
    @(negedge clk);
    number = 8'd47;
    step(1);  // E0
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++; $display("FAIL c47_busy_rise: got %b want 1", busy_a);
    end
    if (busy_a === 1'b1) busy_cycles++;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (busy_a === 1'b1) busy_cycles++;
      n_checks++;
      if (hex0_a !== 7'b1000000 || hex1_a !== 7'b1000000) begin
        n_fail++; $display("FAIL c47_hold: E0+%0d got %b %b want 1000000 1000000", i, hex1_a, hex0_a);
      end
    end
    step(1);  // E0+9
    n_checks++;
    if (tens_a !== 4'd4 || units_a !== 4'd7) begin
      n_fail++; $display("FAIL c47_bcd: got %0d%0d want 47", tens_a, units_a);
    end
    n_checks++;
    if (hex1_a !== 7'b0011001 || hex0_a !== 7'b1111000) begin
      n_fail++; $display("FAIL c47_hex: got %b %b want 0011001 1111000", hex1_a, hex0_a);
    end
    n_checks++;
    if (busy_a !== 1'b0 || busy_cycles != 9) begin
      n_fail++; $display("FAIL c47_busy_len: busy %b cycles %0d want 0 and 9", busy_a, busy_cycles);
    end
  endtask

  task automatic test_wrap();
    apply(8'd99);
    n_checks++;
    if (hex1_a !== 7'b0010000 || hex0_a !== 7'b0010000 || tens_a !== 4'd9 || units_a !== 4'd9) begin
      n_fail++; $display("FAIL wrap_99: got %b %b %0d%0d want 0010000 0010000 99", hex1_a, hex0_a, tens_a, units_a);
    end
    apply(8'd0);
    n_checks++;
    if (hex1_a !== 7'b1000000 || hex0_a !== 7'b1000000 || tens_a !== 4'd0 || units_a !== 4'd0) begin
      n_fail++; $display("FAIL wrap_00: got %b %b %0d%0d want 1000000 1000000 00", hex1_a, hex0_a, tens_a, units_a);
    end
    apply(8'd5);
    n_checks++;
    if (hex1_b !== 7'b1111111 || hex0_b !== 7'b0010010) begin
      n_fail++; $display("FAIL blank_05: got %b %b want 1111111 0010010", hex1_b, hex0_b);
    end
    n_checks++;
    if (hex1_a !== 7'b1000000 || hex0_a !== 7'b0010010) begin
      n_fail++; $display("FAIL noblank_05: got %b %b want 1000000 0010010", hex1_a, hex0_a);
    end
  endtask

  task automatic test_range();
    apply(8'd150);
    n_checks++;
    if (hex1_a !== 7'b0111111 || hex0_a !== 7'b0111111 || rerr_a !== 1'b1) begin
      n_fail++; $display("FAIL range_150_hex: got %b %b err %b want 0111111 0111111 err 1", hex1_a, hex0_a, rerr_a);
    end
    n_checks++;
    if (tens_a !== 4'hF || units_a !== 4'hF || hex1_b !== 7'b0111111) begin
      n_fail++; $display("FAIL range_150_bcd: got %h%h hex1_b %b want FF 0111111", tens_a, units_a, hex1_b);
    end
    apply(8'd12);
    n_checks++;
    if (rerr_a !== 1'b0 || hex1_a !== 7'b1111001 || hex0_a !== 7'b0100100 || tens_a !== 4'd1 || units_a !== 4'd2) begin
      n_fail++; $display("FAIL range_12: got err %b %b %b %0d%0d want err 0 1111001 0100100 12", rerr_a, hex1_a, hex0_a, tens_a, units_a);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    number = 8'd23;
    step(1);   // E0
    step(4);   // E0+4
    number = 8'd24;
    step(4);   // E0+8
    n_checks++;
    if (hex1_a !== 7'b1111001 || hex0_a !== 7'b0100100) begin
      n_fail++; $display("FAIL b2b_hold12: got %b %b want 1111001 0100100", hex1_a, hex0_a);
    end
    step(1);   // E0+9
    n_checks++;
    if (hex1_a !== 7'b0100100 || hex0_a !== 7'b0110000) begin
      n_fail++; $display("FAIL b2b_23: got %b %b want 0100100 0110000", hex1_a, hex0_a);
    end
    step(9);   // E0+18
    n_checks++;
    if (hex0_a !== 7'b0110000 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL b2b_pre24: got %b busy %b want 0110000 busy 1", hex0_a, busy_a);
    end
    step(1);   // E0+19
    n_checks++;
    if (hex1_a !== 7'b0100100 || hex0_a !== 7'b0011001 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL b2b_24: got %b %b busy %b want 0100100 0011001 busy 0", hex1_a, hex0_a, busy_a);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    number = 8'd88;
    step(1);   // E0
    step(4);   // E0+4
    reset = 1'b1;
    step(1);   // E0+5
    reset = 1'b0;
    n_checks++;
    if (hex1_a !== 7'b1000000 || hex0_a !== 7'b1000000 || busy_a !== 1'b0 || tens_a !== 4'd0 || units_a !== 4'd0) begin
      n_fail++; $display("FAIL rmid_00: got %b %b busy %b %0d%0d want 1000000 1000000 busy 0 00", hex1_a, hex0_a, busy_a, tens_a, units_a);
    end
    n_checks++;
    if (hex1_b !== 7'b1111111) begin
      n_fail++; $display("FAIL rmid_blank: got %b want 1111111", hex1_b);
    end
    step(9);
    n_checks++;
    if (hex1_a !== 7'b1000000 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre88: got %b busy %b want 1000000 busy 1", hex1_a, busy_a);
    end
    step(1);
    n_checks++;
    if (hex1_a !== 7'b0000000 || hex0_a !== 7'b0000000 || tens_a !== 4'd8 || units_a !== 4'd8) begin
      n_fail++; $display("FAIL rmid_88: got %b %b %0d%0d want 0000000 0000000 88", hex1_a, hex0_a, tens_a, units_a);
    end
  endtask

  initial begin
    reset  = 1'b1;
    number = 8'd0;
    test_reset();
    test_convert_47();
    test_wrap();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
